// File: rtl/ps2_keymap.sv
// ps2_keymap: PS/2 scancode decoder tracking up to NKEYS mapped keys, with an event FIFO and a register bus.
// Define PS2_KEYMAP_REPEAT_EN to push typematic (repeat) events for makes of already-pressed keys.
module ps2_keymap #(
  parameter int NKEYS      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_code,
  input  logic        i_ncode,
  input  logic [31:0] i_addr,
  input  logic        i_req,
  input  logic        i_wren,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_out,
  output logic        done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef PS2_KEYMAP_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  function automatic logic [8:0] table_default(input int k);
    case (k)
      0:       table_default = 9'h014;
      1:       table_default = 9'h012;
      2:       table_default = 9'h01D;
      3:       table_default = 9'h01C;
      4:       table_default = 9'h01B;
      5:       table_default = 9'h023;
      6:       table_default = 9'h029;
      7:       table_default = 9'h076;
      default: table_default = 9'h000;
    endcase
  endfunction

  logic [8:0]       r_table [NKEYS];
  logic [NKEYS-1:0] r_state;
  logic             r_ext;
  logic             r_brk;
  logic [2:0]       r_skip;
  logic [5:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic [31:0]      r_out;
  logic             r_done;

  logic             w_live, w_pfx_ext, w_pfx_brk, w_pause, w_key_byte;
  logic [8:0]       w_key;
  logic [NKEYS-1:0] w_match, w_hit_oh, w_wr_oh, w_state_next;
  logic             w_hit;
  logic [3:0]       w_hit_idx;
  logic             w_make, w_was, w_wr_clash, w_push, w_push_ok, w_pop;
  logic [5:0]       w_push_ev, w_head;
  logic             w_empty, w_full, w_ovf_set, w_ovf_clr;
  logic [7:0]       w_addr;
  logic             w_rd, w_wr, w_tbl_sel;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_unused = ^{i_addr[31:8], i_wdata[31:9]};

  // Bytes arriving while the pause-sequence skip counter runs are swallowed entirely.
  assign w_live     = i_ncode && (r_skip == 3'd0);
  assign w_pfx_ext  = w_live && (i_code == 8'hE0);
  assign w_pfx_brk  = w_live && (i_code == 8'hF0);
  assign w_pause    = w_live && (i_code == 8'hE1);
  assign w_key_byte = w_live && !w_pfx_ext && !w_pfx_brk && !w_pause;
  assign w_key      = {r_ext, i_code};

  assign w_addr    = i_addr[7:0];
  assign w_rd      = i_req && !i_wren;
  assign w_wr      = i_req && i_wren;
  assign w_tbl_sel = (w_addr[7:6] == 2'b01) && (w_addr[1:0] == 2'b00) &&
                     ({28'd0, w_addr[5:2]} < 32'(NKEYS));

  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_entry
    assign w_match[gi] = (r_table[gi] == w_key) && (r_table[gi][7:0] != 8'h00);
    assign w_wr_oh[gi] = w_wr && w_tbl_sel && (w_addr[5:2] == 4'(gi));
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit_oh  = '0;
    w_hit_idx = 4'd0;
    w_hit     = 1'b0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit_oh    = '0;
        w_hit_oh[i] = 1'b1;
        w_hit_idx   = 4'(i);
        w_hit       = 1'b1;
      end
    end
  end

  assign w_make     = !r_brk;
  assign w_was      = |(r_state & w_hit_oh);
  assign w_wr_clash = |(w_hit_oh & w_wr_oh);
  assign w_push     = w_key_byte && w_hit && !w_wr_clash &&
                      (w_make ? (!w_was || REPEAT_EN) : w_was);
  assign w_push_ev  = {w_make && w_was, w_make, w_hit_idx};

  always_comb begin
    w_state_next = r_state;
    if (w_key_byte && w_hit) begin
      if (w_make) w_state_next = r_state | w_hit_oh;
      else        w_state_next = r_state & ~w_hit_oh;
    end
    w_state_next = w_state_next & ~w_wr_oh;
  end

  assign w_head    = r_fifo[r_rd_ptr];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = w_rd && (w_addr == 8'h04) && !w_empty;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_ovf_clr = w_wr && (w_addr == 8'h08) && i_wdata[8];

  always_comb begin
    w_rdata = 32'd0;
    case (w_addr)
      8'h00: w_rdata[NKEYS-1:0] = r_state;
      8'h04: if (!w_empty) w_rdata = {1'b1, 22'd0, w_head[5], w_head[4], 3'd0, w_head[3:0]};
      8'h08: begin
        w_rdata[8]   = r_ovf;
        w_rdata[4:0] = 5'(r_count);
      end
      default: begin
        for (int i = 0; i < NKEYS; i++) begin
          if (w_tbl_sel && (w_addr[5:2] == 4'(i))) w_rdata[8:0] = r_table[i];
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= w_push_ev;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= '0;
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_skip   <= 3'd0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_out    <= 32'd0;
      r_done   <= 1'b0;
      for (int i = 0; i < NKEYS; i++) r_table[i] <= table_default(i);
    end else begin
      r_state <= w_state_next;
      r_done  <= i_req;
      if (w_rd) r_out <= w_rdata;
      if (i_ncode) begin
        if (r_skip != 3'd0) r_skip <= r_skip - 3'd1;
        else if (w_pause)   r_skip <= 3'd7;
      end
      // F0 after E0 must keep ext: an extended break arrives as E0 F0 xx.
      if (w_pfx_ext)                    r_ext <= 1'b1;
      else if (w_key_byte || w_pause)   r_ext <= 1'b0;
      if (w_pfx_brk)                    r_brk <= 1'b1;
      else if (w_key_byte || w_pause)   r_brk <= 1'b0;
      for (int i = 0; i < NKEYS; i++) begin
        if (w_wr_oh[i]) r_table[i] <= i_wdata[8:0];
      end
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o_out = r_out;
  assign done  = r_done;
endmodule

// File: tb/tb_ps2_keymap.sv
// tb_ps2_keymap: scoreboard bench for ps2_keymap; expected bus responses come from a queue-based key model.
`timescale 1ns/1ps
module tb_ps2_keymap;
  localparam int NK = 8;
  localparam int FD = 8;
`ifdef PS2_KEYMAP_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_code = 8'h00;
  logic        i_ncode = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_req = 1'b0;
  logic        i_wren = 1'b0;
  logic [31:0] i_wdata = 32'd0;
  logic [31:0] o_out;
  logic        done;

  always #5 clk = ~clk;

  ps2_keymap #(.NKEYS(NK), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_code(i_code), .i_ncode(i_ncode),
    .i_addr(i_addr), .i_req(i_req), .i_wren(i_wren), .i_wdata(i_wdata),
    .o_out(o_out), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_ack   = 0;
  int unsigned sb_q[$];
  int unsigned mon_exp;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Reference model: key table, pressed set and event queue as plain integers.
  int unsigned m_tbl[16];
  bit [15:0]   m_state;
  int unsigned m_evq[$];
  bit          m_ovf, m_ext, m_brk;
  int          m_skip;
  int unsigned m_last_out;

  function automatic void m_reset();
    int unsigned defs[8] = '{'h014, 'h012, 'h01D, 'h01C, 'h01B, 'h023, 'h029, 'h076};
    for (int i = 0; i < 16; i++) m_tbl[i] = (i < 8) ? defs[i] : 0;
    m_state = 0; m_evq.delete(); m_ovf = 0; m_ext = 0; m_brk = 0; m_skip = 0; m_last_out = 0;
  endfunction

  function automatic int m_tbl_k(input logic [31:0] addr);
    int a;
    a = int'(addr[7:0]);
    if (a >= 'h40 && a < 'h40 + 4 * NK && a % 4 == 0) return (a - 'h40) / 4;
    return -1;
  endfunction

  function automatic void m_push(input int unsigned ev);
    if (m_evq.size() >= FD) m_ovf = 1;
    else m_evq.push_back(ev);
  endfunction

  function automatic void m_byte(input int unsigned b, input int wr_k);
    int k;
    int unsigned key;
    bit brk;
    if (m_skip > 0) begin m_skip--; return; end
    if (b == 'hE0) m_ext = 1;
    else if (b == 'hF0) m_brk = 1;
    else if (b == 'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
    else begin
      key = (m_ext ? 256 : 0) + b;
      brk = m_brk; m_ext = 0; m_brk = 0;
      k = -1;
      for (int i = 0; i < NK; i++)
        if (k < 0 && m_tbl[i] == key && (m_tbl[i] & 'hFF) != 0) k = i;
      if (k < 0 || k == wr_k) return;
      if (!brk) begin
        if (!m_state[k]) begin m_state[k] = 1; m_push('h80000080 | k); end
        else if (REP) m_push('h80000180 | k);
      end else if (m_state[k]) begin
        m_state[k] = 0; m_push('h80000000 | k);
      end
    end
  endfunction

  function automatic int unsigned m_read(input logic [31:0] addr);
    int a, k;
    a = int'(addr[7:0]);
    k = m_tbl_k(addr);
    if (a == 0) return int'(m_state) & ((1 << NK) - 1);
    if (a == 4) return (m_evq.size() > 0) ? m_evq.pop_front() : 0;
    if (a == 8) return (m_ovf ? 'h100 : 0) | m_evq.size();
    if (k >= 0) return m_tbl[k];
    return 0;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_ack++;
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        $display("[TB] ack %0d: o_out=0x%08h expect=0x%08h", n_ack, o_out, mon_exp);
        check("bus_rdata", o_out, mon_exp);
      end
    end
  end

  // One clock of stimulus: optional scancode strobe plus optional bus request.
  task automatic cyc(input bit nc, input logic [7:0] b, input bit rq, input bit we,
                     input logic [31:0] addr, input logic [31:0] data);
    int wk;
    wk = (rq && we) ? m_tbl_k(addr) : -1;
    if (rq) begin
      if (!we) m_last_out = m_read(addr);
      sb_q.push_back(m_last_out);
      if (we && addr[7:0] == 8'h08 && data[8]) m_ovf = 0;
    end
    if (nc) m_byte(int'(b), wk);
    if (wk >= 0) begin m_tbl[wk] = data & 'h1FF; m_state[wk] = 0; end
    i_ncode = nc; i_code = b; i_req = rq; i_wren = we; i_addr = addr; i_wdata = data;
    @(posedge clk); #1;
    i_ncode = 0; i_req = 0; i_wren = 0;
    if (rq) check("done_pulse", 32'(done), 32'd1);
  endtask

  task automatic kb(input logic [7:0] b);
    cyc(1, b, 0, 0, 0, 0);
  endtask
  task automatic rd(input logic [31:0] a);
    cyc(0, 8'h00, 1, 0, a, 0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 8'h00, 1, 1, a, d);
  endtask
  task automatic drain();
    for (int i = 0; i < FD + 1; i++) rd(32'h04);
  endtask

  task automatic do_reset(input bit with_req);
    i_rst = 1; i_req = with_req; i_wren = 0; i_addr = 32'h0;
    @(posedge clk); #1;
    i_req = 0;
    @(posedge clk); #1;
    i_rst = 0;
    m_reset(); sb_q.delete();
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", o_out, 32'd0);
  endtask

  logic [7:0] pool[14] = '{8'h14, 8'h12, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h76,
                           8'hE0, 8'hF0, 8'hE1, 8'h5A, 8'h00, 8'h1D};
  logic [31:0] raddr[8] = '{32'h00, 32'h04, 32'h04, 32'h08, 32'h0C, 32'h104, 32'h3C, 32'h80};

  initial begin
    m_reset();
    do_reset(0);
    rd(0); rd(4); rd(8); rd(32'h0C);
    for (int k = 0; k < NK + 2; k++) rd(32'h40 + 4 * k);

    // W make then break
    kb(8'h1D); rd(0); kb(8'hF0); kb(8'h1D); rd(0); rd(4); rd(4); rd(4);
    // extended Ctrl unmapped, plain Ctrl mapped
    kb(8'hE0); kb(8'h14); rd(0); kb(8'h14); rd(0); kb(8'hF0); kb(8'h14); drain();
    // break of unmapped key must not leave brk stuck
    kb(8'hF0); kb(8'h5A); kb(8'h29); rd(0); kb(8'hF0); kb(8'h29); drain();

    // overflow after 9 transitions, clear, then push+pop while full
    do_reset(0);
    foreach (pool[i]) if (i < 8) kb(pool[i]);
    kb(8'hF0); kb(8'h14); rd(8);
    wr(8, 32'h100); rd(8);
    kb(8'hF0); cyc(1, 8'h12, 1, 0, 32'h04, 0); rd(8); drain(); rd(8);

    // pause sequence
    do_reset(0);
    kb(8'hE1); kb(8'h14); kb(8'h77); kb(8'hE1); kb(8'hF0); kb(8'h14); kb(8'hF0); kb(8'h77);
    rd(0); rd(8);
    // typematic makes
    kb(8'h1C); kb(8'h1C); kb(8'h1C); rd(8); drain();

    // same-cycle table write wins over scancode
    cyc(1, 8'h1D, 1, 1, 32'h48, 32'h01D); rd(0); rd(8);
    kb(8'hF0); kb(8'h1D); rd(8);
    // duplicate entry resolves lowest, zero code never matches
    wr(32'h5C, 32'h01D); kb(8'h1D); rd(0); rd(4); rd(32'h5C);
    wr(32'h40, 32'h100); kb(8'hE0); kb(8'h00); kb(8'h00); rd(0); rd(8);

    // reset mid-sequence, with a request in flight
    kb(8'hE0); do_reset(1); kb(8'h14); rd(0);
    kb(8'hE1); do_reset(0); kb(8'h1D); rd(0); rd(4);

    // randomized traffic
    do_reset(0);
    for (int n = 0; n < 600; n++) begin
      int op;
      logic [31:0] a, d;
      logic [7:0] b;
      op = int'($urandom_range(0, 99));
      b  = pool[$urandom_range(0, 13)];
      a  = raddr[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) a = 32'h40 + 4 * $urandom_range(0, 9);
      a[31:8] = 24'($urandom);
      d = $urandom;
      if (op < 55) kb(b);
      else if (op < 80) rd(a);
      else if (op < 86) wr(32'h08, d);
      else if (op < 90) wr(32'h40 + 4 * $urandom_range(0, 9), {$urandom_range(0, 1) == 0 ? 24'd0 : 24'd1, pool[$urandom_range(0, 13)]});
      else cyc(1, b, 1, op < 95, a, {23'd0, 1'b0, pool[$urandom_range(0, 13)]});
    end
    rd(0); rd(8); drain();

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
